// File: rtl/tmr_scrub_pkg.sv
// ---------------------------------------------------------------------------
// tmr_scrub_pkg : scrub FSM state encoding and saturating-counter widths
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tmr_scrub_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RD   = 3'd2,
    S_RW   = 3'd3,
    S_WB   = 3'd4,
    S_VR   = 3'd5,
    S_VC   = 3'd6
  } scrub_state_e;

  localparam int PASS_CNT_W = 16;
  localparam int VERR_W     = 8;

endpackage

`default_nettype wire

// File: rtl/tmr_scrub_arb.sv
// ---------------------------------------------------------------------------
// tmr_scrub_arb : host-priority mux of host/scrub requests onto the memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmr_scrub_arb #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_we_i,
  input  logic          host_re_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  input  logic          scrub_we_i,
  input  logic          scrub_re_i,
  input  logic [AW-1:0] scrub_addr_i,
  input  logic [DW-1:0] scrub_wdata_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          host_req_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          host_rvalid_o,
  output logic [DW-1:0] host_rdata_o
);

  logic host_rd;
  logic scrub_act;
  logic rvalid_q;

  assign host_rd   = host_re_i & ~host_we_i;
  assign scrub_act = ~host_req_o & (scrub_we_i | scrub_re_i);

  // Any host request owns the whole cycle; scrub only drives when the host is idle.
  assign host_req_o  = host_we_i | host_re_i;
  assign mem_we_o    = host_req_o ? host_we_i : scrub_we_i;
  assign mem_re_o    = host_req_o ? host_rd : scrub_re_i;
  assign mem_addr_o  = host_req_o ? host_addr_i : (scrub_act ? scrub_addr_i : '0);
  assign mem_wdata_o = host_we_i ? host_wdata_i :
                       ((scrub_act & scrub_we_i) ? scrub_wdata_i : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rvalid_q <= 1'b0;
    else     rvalid_q <= host_rd;
  end

  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = rvalid_q ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: rtl/tmr_mem_scrubber.sv
// ---------------------------------------------------------------------------
// tmr_mem_scrubber : host port + background read/write-back scrub of a TMR memory
// Optional verify-after-write step enabled by macro SCRUB_VERIFY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmr_mem_scrubber
  import tmr_scrub_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int IW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en_i,
  input  logic [IW-1:0]         interval_i,
  input  logic                  host_we_i,
  input  logic                  host_re_i,
  input  logic [AW-1:0]         host_addr_i,
  input  logic [DW-1:0]         host_wdata_i,
  output logic                  host_rvalid_o,
  output logic [DW-1:0]         host_rdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DW-1:0]         mem_wdata_o,
  input  logic [DW-1:0]         mem_rdata_i,
  output logic                  scrub_busy_o,
  output logic                  pass_done_o,
  output logic [PASS_CNT_W-1:0] pass_count_o,
  output logic [VERR_W-1:0]     verify_err_o
);

  scrub_state_e          state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         hold_q, hold_d;
  logic                  cancel_q, cancel_d;
  logic                  pass_done_q, pass_done_d;
  logic [PASS_CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic                  scrub_we, scrub_re, host_req, hit, advance;

  assign hit = host_we_i & (host_addr_i == ptr_q);

  tmr_scrub_arb #(.AW(AW), .DW(DW)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .host_we_i    (host_we_i),
    .host_re_i    (host_re_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .scrub_we_i   (scrub_we),
    .scrub_re_i   (scrub_re),
    .scrub_addr_i (ptr_q),
    .scrub_wdata_i(hold_q),
    .mem_rdata_i  (mem_rdata_i),
    .host_req_o   (host_req),
    .mem_we_o     (mem_we_o),
    .mem_re_o     (mem_re_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o)
  );

`ifdef SCRUB_VERIFY_EN
  logic [VERR_W-1:0] verr_q, verr_d;
  assign verify_err_o = verr_q;
`else
  assign verify_err_o = '0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    cancel_d    = cancel_q;
    pass_done_d = 1'b0;
    pass_cnt_d  = pass_cnt_q;
    scrub_we    = 1'b0;
    scrub_re    = 1'b0;
    advance     = 1'b0;
`ifdef SCRUB_VERIFY_EN
    verr_d      = verr_q;
`endif
    case (state_q)
      S_IDLE: if (scrub_en_i) begin
        cnt_d   = interval_i;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!scrub_en_i) begin
          state_d = S_IDLE;
        end else if (cnt_q[IW-1:1] == '0) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q - IW'(1);
        end
      end
      S_RD: if (!host_req) begin
        scrub_re = 1'b1;
        cancel_d = 1'b0;
        state_d  = S_RW;
      end
      S_RW: begin
        hold_d  = mem_rdata_i;
        state_d = S_WB;
        if (hit) cancel_d = 1'b1;
      end
      // A host write to this address since the read makes hold_q stale: drop the write-back.
      S_WB: begin
        if (cancel_q || hit) begin
          advance = 1'b1;
        end else if (!host_req) begin
          scrub_we = 1'b1;
`ifdef SCRUB_VERIFY_EN
          state_d  = S_VR;
`else
          advance  = 1'b1;
`endif
        end
      end
`ifdef SCRUB_VERIFY_EN
      S_VR: if (!host_req) begin
        scrub_re = 1'b1;
        state_d  = S_VC;
      end
      S_VC: begin
        if (mem_rdata_i != hold_q && verr_q != '1) verr_d = verr_q + VERR_W'(1);
        advance = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      ptr_d    = ptr_q + AW'(1);
      cancel_d = 1'b0;
      if (ptr_q == '1) begin
        pass_done_d = 1'b1;
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + PASS_CNT_W'(1);
      end
      if (!scrub_en_i) begin
        state_d = S_IDLE;
      end else if (interval_i == '0) begin
        state_d = S_RD;
      end else begin
        cnt_d   = interval_i;
        state_d = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      cancel_q    <= 1'b0;
      pass_done_q <= 1'b0;
      pass_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      cancel_q    <= cancel_d;
      pass_done_q <= pass_done_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

`ifdef SCRUB_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) verr_q <= '0;
    else     verr_q <= verr_d;
  end
`endif

  assign scrub_busy_o = (state_q != S_IDLE) && (state_q != S_WAIT);
  assign pass_done_o  = pass_done_q;
  assign pass_count_o = pass_cnt_q;

endmodule

`default_nettype wire
